micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter AW, default 8, meaning control-store address width.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  begin execution at start_addr; honoured only in IDLE or HALT.
REQ-005 SHALL have port start_addr  in  AW  first microinstruction address.
REQ-006 SHALL have port stall  in  1  downstream hold; freezes the sequencer while 1.
REQ-007 SHALL have port flag_n, flag_z  in  1 each  datapath negative and zero flags for branches.
REQ-008 SHALL have port cs_addr  out  AW  control-store read address, registered.
REQ-009 SHALL have port cs_en  out  1  control-store read strobe.
REQ-010 SHALL have port cs_data  in  32  microword, valid the cycle after cs_en=1.
REQ-011 SHALL have ports ALU3 (4), SH3 (2), C3 (6), T3 (7)  out  registered microinstruction fields feeding pipeline stage 3.
REQ-012 SHALL have port valid3  out  1  fields on ALU3/SH3/C3/T3 are a real microinstruction.
REQ-013 SHALL have port halted  out  1  sequencer is in HALT.

Function
REQ-014 SHALL decode the microword as follows: [31] HALT, [30:28] COND, [27:20] ADDR, [19:16] ALU, [15:14] SH, [13:8] C, [7:1] T, [0] reserved (ignored).
REQ-015 SHALL implement states IDLE, FETCH, ISSUE and HALT.
REQ-016 IDLE: SHALL hold valid3=0 and cs_en=0; start=1 SHALL load MPC=start_addr, drive cs_addr=start_addr with cs_en=1, and go to FETCH.
REQ-017 FETCH: SHALL register the cs_data fields into ALU3/SH3/C3/T3, set valid3=1, compute next MPC and go to ISSUE.
REQ-018 ISSUE with stall=0, HALT=0: SHALL drive cs_addr=next MPC with cs_en=1, clear valid3 and go to FETCH; throughput SHALL be one microinstruction per 2 cycles.
REQ-019 ISSUE with HALT=1: SHALL clear valid3 and go to HALT; the halting word's fields SHALL still be issued for exactly one valid3 cycle.
REQ-020 HALT: SHALL set halted=1; start=1 SHALL behave as in IDLE and clear halted.
REQ-021 SHALL implement COND codes as follows:
- 000: MPC+1.
- 001: ADDR if flag_n else MPC+1.
- 010: ADDR if flag_z else MPC+1.
- 011: ADDR.
- 100 (CALL): RET_REG=MPC+1, then ADDR.
- 101 (RET): RET_REG.
- 110/111: treated as 000.
REQ-022 SHALL sample flag_n and flag_z in the FETCH cycle in which the word is registered.
REQ-023 MPC+1 SHALL wrap modulo 2^AW (address 255 -> 0 for AW=8); RET_REG SHALL be single-depth, and a CALL SHALL overwrite it.
REQ-024 stall=1 SHALL freeze state, MPC, RET_REG and all outputs, including valid3, and SHALL force cs_en=0; no cs_data is consumed while stalled.
REQ-025 start asserted in FETCH or ISSUE SHALL be ignored.
REQ-026 When valid3=0, ALU3/SH3/C3/T3 SHALL be driven to zero, which is the NOP microinstruction.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, MPC=0, RET_REG=0, cs_addr=0, cs_en=0, ALU3=0, SH3=0, C3=0, T3=0, valid3=0 and halted=0.
REQ-028 Reset asserted mid-fetch SHALL discard any pending cs_data; the first action after release SHALL be to wait in IDLE for start.

Structure
REQ-029 Package micro_pkg SHALL hold:
- microword field bit positions and widths;
- COND encodings;
- the state enumeration;
- the NOP constant.
REQ-030 Next-address selection (COND, flags, RET_REG, wrap) SHALL be a combinational sub-module micro_next_addr; the remaining logic SHALL live in micro_sequencer.

Verification
REQ-031 Reset then start, start_addr=0x10, sequential words with COND=000 -> cs_addr 0x10, 0x11, 0x12; each field set shown with valid3=1 for one cycle every 2 cycles.
REQ-032 Word at 0x20 with COND=001, ADDR=0x40: flag_n=1 -> next cs_addr 0x40; flag_n=0 -> next cs_addr 0x21.
REQ-033 CALL at 0x05 (ADDR=0x80), then RET at 0x80 -> cs_addr 0x80, then 0x06; word at 0xFF with COND=000 -> next cs_addr 0x00.
REQ-034 stall=1 for 3 cycles during ISSUE -> outputs, valid3 and cs_addr unchanged and cs_en=0; execution resumes with no word lost or duplicated.
REQ-035 HALT word ALU=0xA, SH=1, C=0x15, T=0x33 -> fields issued with valid3=1 once, then halted=1; start mid-run is ignored, and start while halted resumes at start_addr.
REQ-036 reset_n pulsed low during FETCH -> all outputs 0 asynchronously; no issue occurs until a new start.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the micro-sequencer: microword layout, branch condition codes,
// sequencer states and the NOP field set.
package micro_pkg;

  localparam int HALT_BIT = 31;
  localparam int COND_LSB = 28;
  localparam int COND_W   = 3;
  localparam int ADDR_LSB = 20;
  localparam int ADDR_W   = 8;
  localparam int ALU_LSB  = 16;
  localparam int ALU_W    = 4;
  localparam int SH_LSB   = 14;
  localparam int SH_W     = 2;
  localparam int C_LSB    = 8;
  localparam int C_W      = 6;
  localparam int T_LSB    = 1;
  localparam int T_W      = 7;

  typedef logic [COND_W-1:0] cond_t;

  localparam cond_t COND_SEQ  = 3'b000;
  localparam cond_t COND_BRN  = 3'b001;
  localparam cond_t COND_BRZ  = 3'b010;
  localparam cond_t COND_JMP  = 3'b011;
  localparam cond_t COND_CALL = 3'b100;
  localparam cond_t COND_RET  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [SH_W-1:0]  sh;
    logic [C_W-1:0]   c;
    logic [T_W-1:0]   t;
  } fields_t;

  localparam fields_t NOP = '0;

  typedef struct packed {
    logic              halt;
    cond_t             cond;
    logic [ADDR_W-1:0] addr;
    fields_t           f;
  } uword_t;

  function automatic uword_t decode(input logic [31:0] w);
    uword_t u;
    u.halt  = w[HALT_BIT];
    u.cond  = w[COND_LSB +: COND_W];
    u.addr  = w[ADDR_LSB +: ADDR_W];
    u.f.alu = w[ALU_LSB +: ALU_W];
    u.f.sh  = w[SH_LSB +: SH_W];
    u.f.c   = w[C_LSB +: C_W];
    u.f.t   = w[T_LSB +: T_W];
    return u;
  endfunction

endpackage

// File: rtl/micro_next_addr.sv
// Next microprogram address selection from COND, flags and the return register.
// Purely combinational (zero latency); no flow control of its own.
module micro_next_addr
  import micro_pkg::*;
#(
  parameter int AW = 8
) (
  input  cond_t             cond_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flag_n_i,
  input  logic              flag_z_i,
  input  logic [AW-1:0]     mpc_i,
  input  logic [AW-1:0]     ret_i,
  output logic [AW-1:0]     next_mpc_o,
  output logic              ret_we_o,
  output logic [AW-1:0]     ret_d_o
);

  logic [AW-1:0] seq_addr;
  logic [AW-1:0] jmp_addr;

  // AW-bit add wraps the top of the control store back to address 0.
  assign seq_addr = mpc_i + AW'(1);
  assign jmp_addr = AW'(addr_i);
  assign ret_d_o  = seq_addr;

  always_comb begin
    next_mpc_o = seq_addr;
    ret_we_o   = 1'b0;
    case (cond_i)
      COND_BRN: if (flag_n_i) next_mpc_o = jmp_addr;
      COND_BRZ: if (flag_z_i) next_mpc_o = jmp_addr;
      COND_JMP: next_mpc_o = jmp_addr;
      COND_CALL: begin
        next_mpc_o = jmp_addr;
        ret_we_o   = 1'b1;
      end
      COND_RET: next_mpc_o = ret_i;
      default:  next_mpc_o = seq_addr;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches a microword, issues its fields to stage 3, one word per 2 cycles.
// stall freezes every register and output and masks cs_en, so no control-store data is consumed.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          stall,
  input  logic          flag_n,
  input  logic          flag_z,
  output logic [AW-1:0] cs_addr,
  output logic          cs_en,
  input  logic [31:0]   cs_data,
  output logic [3:0]    ALU3,
  output logic [1:0]    SH3,
  output logic [5:0]    C3,
  output logic [6:0]    T3,
  output logic          valid3,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [AW-1:0] mpc_q, mpc_d;
  logic [AW-1:0] ret_q, ret_d;
  logic [AW-1:0] cs_addr_q, cs_addr_d;
  logic          cs_en_q, cs_en_d;
  fields_t       fields_q, fields_d;
  logic          valid3_q, valid3_d;
  logic          halted_q, halted_d;
  logic          halt_pend_q, halt_pend_d;

  uword_t        word;
  logic [AW-1:0] nxt_mpc;
  logic          ret_we;
  logic [AW-1:0] ret_nxt;
  logic          unused_rsvd;

  assign word        = decode(cs_data);
  assign unused_rsvd = cs_data[0];

  micro_next_addr #(
    .AW(AW)
  ) u_next_addr (
    .cond_i    (word.cond),
    .addr_i    (word.addr),
    .flag_n_i  (flag_n),
    .flag_z_i  (flag_z),
    .mpc_i     (mpc_q),
    .ret_i     (ret_q),
    .next_mpc_o(nxt_mpc),
    .ret_we_o  (ret_we),
    .ret_d_o   (ret_nxt)
  );

  always_comb begin
    state_d     = state_q;
    mpc_d       = mpc_q;
    ret_d       = ret_q;
    cs_addr_d   = cs_addr_q;
    cs_en_d     = cs_en_q;
    fields_d    = fields_q;
    valid3_d    = valid3_q;
    halted_d    = halted_q;
    halt_pend_d = halt_pend_q;

    if (!stall) begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            mpc_d     = start_addr;
            cs_addr_d = start_addr;
            cs_en_d   = 1'b1;
            halted_d  = 1'b0;
            state_d   = ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Flags are sampled here, together with the word they qualify.
          fields_d    = word.f;
          valid3_d    = 1'b1;
          halt_pend_d = word.halt;
          mpc_d       = nxt_mpc;
          if (ret_we) ret_d = ret_nxt;
          cs_en_d     = 1'b0;
          state_d     = ST_ISSUE;
        end
        ST_ISSUE: begin
          valid3_d = 1'b0;
          fields_d = NOP;
          if (halt_pend_q) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            cs_addr_d = mpc_q;
            cs_en_d   = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mpc_q       <= '0;
      ret_q       <= '0;
      cs_addr_q   <= '0;
      cs_en_q     <= 1'b0;
      fields_q    <= NOP;
      valid3_q    <= 1'b0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mpc_q       <= mpc_d;
      ret_q       <= ret_d;
      cs_addr_q   <= cs_addr_d;
      cs_en_q     <= cs_en_d;
      fields_q    <= fields_d;
      valid3_q    <= valid3_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign cs_addr = cs_addr_q;
  assign cs_en   = cs_en_q & ~stall;
  assign ALU3    = fields_q.alu;
  assign SH3     = fields_q.sh;
  assign C3      = fields_q.c;
  assign T3      = fields_q.t;
  assign valid3  = valid3_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: branch table plus hand-written stall/halt/reset sequences,
// with fetch addresses and issued fields checked against expectation queues.
`timescale 1ns/1ps
module tb_micro_sequencer;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          stall = 1'b0;
  logic          flag_n = 1'b0;
  logic          flag_z = 1'b0;
  logic [AW-1:0] cs_addr;
  logic          cs_en;
  logic [31:0]   cs_data;
  logic [3:0]    ALU3;
  logic [1:0]    SH3;
  logic [5:0]    C3;
  logic [6:0]    T3;
  logic          valid3;
  logic          halted;

  logic [31:0]   mem [256];
  logic [18:0]   got_fld;
  logic [AW-1:0] exp_addr_q [$];
  logic [18:0]   exp_fld_q  [$];
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] cond;
    logic [7:0] addr;
    logic       fn;
    logic       fz;
    logic [7:0] nxt;
  } vec_t;

  vec_t vecs [11];

  always #5 clock = ~clock;

  assign cs_data = mem[cs_addr];
  assign got_fld = {ALU3, SH3, C3, T3};

  micro_sequencer #(.AW(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .stall     (stall),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .cs_addr   (cs_addr),
    .cs_en     (cs_en),
    .cs_data   (cs_data),
    .ALU3      (ALU3),
    .SH3       (SH3),
    .C3        (C3),
    .T3        (T3),
    .valid3    (valid3),
    .halted    (halted)
  );

  function automatic logic [31:0] mk_word(input logic h, input logic [2:0] cond,
                                          input logic [7:0] addr, input logic [18:0] f);
    return {h, cond, addr, f, 1'b1};
  endfunction

  function automatic logic [18:0] fld(input int i);
    return 19'((i + 1) * 32'h0001_3579);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    start   = 1'b0;
    stall   = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    exp_addr_q.delete();
    exp_fld_q.delete();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic go(input logic [7:0] a);
    start_addr = a;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic drained(input string name);
    chk({name, "_addr_drained"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_fld_drained"}, 32'(exp_fld_q.size()), 32'd0);
  endtask

  task automatic expect_word(input logic [7:0] a, input logic [18:0] f);
    exp_addr_q.push_back(a);
    exp_fld_q.push_back(f);
  endtask

  // Scoreboard: a fetch is a cycle with cs_en high, an issue is a valid3 cycle not held by stall.
  always @(negedge clock) begin
    if (reset_n) begin
      if (cs_en) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got cs_addr %h, expected no fetch", cs_addr);
        end else begin
          chk("fetch_addr", 32'(cs_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (valid3 && !stall) begin
        if (exp_fld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got fields %h, expected no issue", got_fld);
        end else begin
          chk("issue_fields", 32'(got_fld), 32'(exp_fld_q.pop_front()));
        end
      end
      if (!valid3) chk("nop_when_invalid", 32'(got_fld), 32'd0);
    end
  end

  initial begin
    vecs[0]  = '{8'h10, 3'b000, 8'h55, 1'b0, 1'b0, 8'h11};
    vecs[1]  = '{8'h20, 3'b001, 8'h40, 1'b1, 1'b0, 8'h40};
    vecs[2]  = '{8'h20, 3'b001, 8'h40, 1'b0, 1'b1, 8'h21};
    vecs[3]  = '{8'h30, 3'b010, 8'h70, 1'b0, 1'b1, 8'h70};
    vecs[4]  = '{8'h30, 3'b010, 8'h70, 1'b1, 1'b0, 8'h31};
    vecs[5]  = '{8'h40, 3'b011, 8'h90, 1'b0, 1'b0, 8'h90};
    vecs[6]  = '{8'h50, 3'b101, 8'h33, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{8'hFF, 3'b000, 8'h12, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{8'h60, 3'b110, 8'h08, 1'b1, 1'b1, 8'h61};
    vecs[9]  = '{8'h61, 3'b111, 8'h08, 1'b1, 1'b1, 8'h62};
    vecs[10] = '{8'hFE, 3'b100, 8'h80, 1'b0, 1'b0, 8'h80};

    clear_mem();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_cs_addr", 32'(cs_addr), 32'd0);
    chk("rst_cs_en", 32'(cs_en), 32'd0);
    chk("rst_valid3", 32'(valid3), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fields", 32'(got_fld), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Branch table: one word under test, then a halting word at the expected target.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      clear_mem();
      flag_n = vecs[i].fn;
      flag_z = vecs[i].fz;
      mem[vecs[i].pc]  = mk_word(1'b0, vecs[i].cond, vecs[i].addr, fld(i));
      mem[vecs[i].nxt] = mk_word(1'b1, 3'b000, 8'h00, fld(i + 20));
      expect_word(vecs[i].pc, fld(i));
      expect_word(vecs[i].nxt, fld(i + 20));
      go(vecs[i].pc);
      run_until_halt(20);
      drained("branch_vec");
    end
    flag_n = 1'b0;
    flag_z = 1'b0;

    // Sequential run: valid3 alternates every cycle, then halted.
    do_reset();
    clear_mem();
    mem[8'h10] = mk_word(1'b0, 3'b000, 8'h00, fld(30));
    mem[8'h11] = mk_word(1'b0, 3'b000, 8'h00, fld(31));
    mem[8'h12] = mk_word(1'b1, 3'b000, 8'h00, fld(32));
    expect_word(8'h10, fld(30));
    expect_word(8'h11, fld(31));
    expect_word(8'h12, fld(32));
    go(8'h10);
    for (int k = 0; k < 7; k++) begin
      chk("seq_valid3", 32'(valid3), 32'(k % 2));
      tick();
    end
    chk("seq_halted", 32'(halted), 32'd1);
    drained("seq");

    // CALL then RET returns to the word after the call.
    do_reset();
    clear_mem();
    mem[8'h05] = mk_word(1'b0, 3'b100, 8'h80, fld(33));
    mem[8'h80] = mk_word(1'b0, 3'b101, 8'h00, fld(34));
    mem[8'h06] = mk_word(1'b1, 3'b000, 8'h00, fld(35));
    expect_word(8'h05, fld(33));
    expect_word(8'h80, fld(34));
    expect_word(8'h06, fld(35));
    go(8'h05);
    run_until_halt(20);
    drained("call_ret");

    // Stall three cycles in ISSUE, then one cycle in FETCH.
    do_reset();
    clear_mem();
    mem[8'h10] = mk_word(1'b0, 3'b000, 8'h00, fld(40));
    mem[8'h11] = mk_word(1'b0, 3'b000, 8'h00, fld(41));
    mem[8'h12] = mk_word(1'b1, 3'b000, 8'h00, fld(42));
    expect_word(8'h10, fld(40));
    expect_word(8'h11, fld(41));
    expect_word(8'h12, fld(42));
    go(8'h10);
    tick();
    stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_issue_valid3", 32'(valid3), 32'd1);
      chk("stall_issue_cs_en", 32'(cs_en), 32'd0);
      chk("stall_issue_cs_addr", 32'(cs_addr), 32'h10);
      chk("stall_issue_fields", 32'(got_fld), 32'(fld(40)));
      tick();
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    chk("stall_fetch_cs_en", 32'(cs_en), 32'd0);
    chk("stall_fetch_cs_addr", 32'(cs_addr), 32'h11);
    tick();
    chk("stall_fetch_hold_cs_en", 32'(cs_en), 32'd0);
    chk("stall_fetch_hold_valid3", 32'(valid3), 32'd0);
    chk("stall_fetch_hold_cs_addr", 32'(cs_addr), 32'h11);
    stall = 1'b0;
    run_until_halt(20);
    drained("stall");

    // Halting word issued once; start ignored mid-run, honoured in HALT.
    do_reset();
    clear_mem();
    mem[8'h10] = mk_word(1'b0, 3'b000, 8'h00, fld(50));
    mem[8'h11] = mk_word(1'b1, 3'b000, 8'h00, {4'hA, 2'd1, 6'h15, 7'h33});
    mem[8'h30] = mk_word(1'b1, 3'b000, 8'h00, fld(51));
    mem[8'h70] = mk_word(1'b1, 3'b000, 8'h00, fld(52));
    expect_word(8'h10, fld(50));
    expect_word(8'h11, {4'hA, 2'd1, 6'h15, 7'h33});
    start_addr = 8'h10;
    start      = 1'b1;
    tick();
    start_addr = 8'h70;
    repeat (3) tick();
    start = 1'b0;
    run_until_halt(20);
    drained("halt");
    tick();
    chk("halt_stays_halted", 32'(halted), 32'd1);
    expect_word(8'h30, fld(51));
    go(8'h30);
    chk("restart_clears_halted", 32'(halted), 32'd0);
    run_until_halt(20);
    drained("restart");

    // Reset pulse while a fetch is outstanding.
    do_reset();
    clear_mem();
    mem[8'h10] = mk_word(1'b0, 3'b000, 8'h00, fld(60));
    mem[8'h11] = mk_word(1'b1, 3'b000, 8'h00, fld(61));
    go(8'h10);
    chk("pre_reset_cs_en", 32'(cs_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_cs_en", 32'(cs_en), 32'd0);
    chk("mid_reset_cs_addr", 32'(cs_addr), 32'd0);
    chk("mid_reset_valid3", 32'(valid3), 32'd0);
    chk("mid_reset_halted", 32'(halted), 32'd0);
    chk("mid_reset_fields", 32'(got_fld), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_reset_idle_valid3", 32'(valid3), 32'd0);
      chk("post_reset_idle_cs_en", 32'(cs_en), 32'd0);
    end
    expect_word(8'h10, fld(60));
    expect_word(8'h11, fld(61));
    go(8'h10);
    run_until_halt(20);
    drained("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
